jpeg_huffman_canon_decoder: RTL

Parametrised, multi-table canonical Huffman decoder for the entropy stage of the JPEG decoder. Tables are loaded in JPEG DHT form (BITS counts + HUFFVAL list) into one of `NUM_TABLES` slots, then expanded internally into mincode/maxcode/valptr. A decode request selects a slot. Serial bits are consumed one per cycle under a valid/ready handshake, and one symbol is returned per request with its code length, or a code error. It sits between the bit unstuffer and the coefficient/run-length stage.

---
 rtl/jpeg_huff_pkg.sv | 13 +
 rtl/jpeg_huff_tbl_store.sv | 80 ++++++++
 rtl/jpeg_huffman_canon_decoder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/jpeg_huff_pkg.sv
// Shared constants and FSM encoding for the canonical Huffman decoder.
package jpeg_huff_pkg;
  localparam int MAX_CODE_LEN = 16;
  localparam int SYM_W        = 8;
  localparam int LEN_W        = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUILD  = 2'd1,
    DECODE = 2'd2,
    OUTPUT = 2'd3
  } state_t;
endpackage

// File: rtl/jpeg_huff_tbl_store.sv
// Per-slot DHT storage (BITS, HUFFVAL) plus derived mincode/maxcode/valptr/has.
// Synchronous write and build ports; all reads are combinational.
module jpeg_huff_tbl_store #(
  parameter int NUM_TABLES   = 4,
  parameter int MAX_CODE_LEN = 16,
  parameter int TSEL_W       = 2,
  parameter int LIDX_W       = 4,
  parameter int CODE_W       = MAX_CODE_LEN + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_is_val,
  input  logic [TSEL_W-1:0] wr_sel,
  input  logic [7:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              bld_en,
  input  logic [TSEL_W-1:0] bld_sel,
  input  logic [LIDX_W-1:0] bld_idx,
  output logic [7:0]        bld_bits,
  input  logic [CODE_W-1:0] bld_mincode,
  input  logic [CODE_W-1:0] bld_maxcode,
  input  logic [8:0]        bld_valptr,
  input  logic              bld_has,
  input  logic [TSEL_W-1:0] rd_sel,
  input  logic [LIDX_W-1:0] rd_idx,
  output logic [CODE_W-1:0] rd_mincode,
  output logic [CODE_W-1:0] rd_maxcode,
  output logic [8:0]        rd_valptr,
  output logic              rd_has,
  input  logic [7:0]        val_idx,
  output logic [7:0]        val_data
);
  logic [7:0]        bits_q    [NUM_TABLES][MAX_CODE_LEN];
  logic [7:0]        huffval_q [NUM_TABLES][256];
  logic [CODE_W-1:0] mincode_q [NUM_TABLES][MAX_CODE_LEN];
  logic [CODE_W-1:0] maxcode_q [NUM_TABLES][MAX_CODE_LEN];
  logic [8:0]        valptr_q  [NUM_TABLES][MAX_CODE_LEN];
  logic              has_q     [NUM_TABLES][MAX_CODE_LEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_TABLES; t++) begin
        for (int l = 0; l < MAX_CODE_LEN; l++) bits_q[t][l] <= '0;
        for (int v = 0; v < 256; v++) huffval_q[t][v] <= '0;
      end
    end else if (wr_en) begin
      if (wr_is_val)
        huffval_q[wr_sel][wr_addr] <= wr_data;
      else if (wr_addr < 8'(MAX_CODE_LEN))
        bits_q[wr_sel][wr_addr[LIDX_W-1:0]] <= wr_data;
    end
  end

  // Derived arrays are written one code length per build cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_TABLES; t++) begin
        for (int l = 0; l < MAX_CODE_LEN; l++) begin
          mincode_q[t][l] <= '0;
          maxcode_q[t][l] <= '0;
          valptr_q[t][l]  <= '0;
          has_q[t][l]     <= 1'b0;
        end
      end
    end else if (bld_en) begin
      mincode_q[bld_sel][bld_idx] <= bld_mincode;
      maxcode_q[bld_sel][bld_idx] <= bld_maxcode;
      valptr_q[bld_sel][bld_idx]  <= bld_valptr;
      has_q[bld_sel][bld_idx]     <= bld_has;
    end
  end

  assign bld_bits   = bits_q[bld_sel][bld_idx];
  assign rd_mincode = mincode_q[rd_sel][rd_idx];
  assign rd_maxcode = maxcode_q[rd_sel][rd_idx];
  assign rd_valptr  = valptr_q[rd_sel][rd_idx];
  assign rd_has     = has_q[rd_sel][rd_idx];
  assign val_data   = huffval_q[rd_sel][val_idx];
endmodule

// File: rtl/jpeg_huffman_canon_decoder.sv
// Multi-slot canonical Huffman decoder: 16-cycle table build, one bit per cycle decode,
// symbol valid one cycle after the last code bit; bit_valid stalls, sym_ready back-pressures.
module jpeg_huffman_canon_decoder #(
  parameter int NUM_TABLES   = 4,
  parameter int MAX_CODE_LEN = 16,
  parameter int TSEL_W       = $clog2(NUM_TABLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tbl_we,
  input  logic              tbl_is_val,
  input  logic [TSEL_W-1:0] tbl_sel,
  input  logic [7:0]        tbl_addr,
  input  logic [7:0]        tbl_data,
  input  logic              tbl_build,
  output logic              tbl_busy,
  input  logic              dec_start,
  input  logic [TSEL_W-1:0] dec_tbl,
  output logic              dec_busy,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [7:0]        sym_out,
  output logic [4:0]        sym_len,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic              code_err
);
  import jpeg_huff_pkg::*;

  localparam int LIDX_W = $clog2(MAX_CODE_LEN);
  localparam int CODE_W = MAX_CODE_LEN + 1;

  state_t                  state;
  logic [TSEL_W-1:0]       bld_sel, dsel;
  logic [LIDX_W-1:0]       bld_idx;
  logic [CODE_W-1:0]       code_acc;
  logic [8:0]              k_acc;
  logic [MAX_CODE_LEN-1:0] c_acc, c_nxt;
  logic [LEN_W-1:0]        n_acc, n_nxt;
  logic [7:0]              bld_bits, val_idx, val_data;
  logic [CODE_W-1:0]       rd_mincode, rd_maxcode, val_sum;
  logic [8:0]              rd_valptr;
  logic                    rd_has, match;

  assign c_nxt   = {c_acc[MAX_CODE_LEN-2:0], bit_in};
  assign n_nxt   = n_acc + 1'b1;
  assign match   = rd_has && (CODE_W'(c_nxt) <= rd_maxcode);
  // Only the low byte of the HUFFVAL offset is meaningful for a 256-entry list.
  assign val_sum = CODE_W'(rd_valptr) + CODE_W'(c_nxt) - rd_mincode;
  assign val_idx = val_sum[7:0];

  jpeg_huff_tbl_store #(
    .NUM_TABLES  (NUM_TABLES),
    .MAX_CODE_LEN(MAX_CODE_LEN),
    .TSEL_W      (TSEL_W),
    .LIDX_W      (LIDX_W),
    .CODE_W      (CODE_W)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (tbl_we && (state == IDLE)),
    .wr_is_val  (tbl_is_val),
    .wr_sel     (tbl_sel),
    .wr_addr    (tbl_addr),
    .wr_data    (tbl_data),
    .bld_en     (state == BUILD),
    .bld_sel    (bld_sel),
    .bld_idx    (bld_idx),
    .bld_bits   (bld_bits),
    .bld_mincode(code_acc),
    .bld_maxcode(code_acc + CODE_W'(bld_bits) - 1'b1),
    .bld_valptr (k_acc),
    .bld_has    (bld_bits != 8'd0),
    .rd_sel     (dsel),
    .rd_idx     (LIDX_W'(n_nxt - 1'b1)),
    .rd_mincode (rd_mincode),
    .rd_maxcode (rd_maxcode),
    .rd_valptr  (rd_valptr),
    .rd_has     (rd_has),
    .val_idx    (val_idx),
    .val_data   (val_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bld_sel   <= '0;
      dsel      <= '0;
      bld_idx   <= '0;
      code_acc  <= '0;
      k_acc     <= '0;
      c_acc     <= '0;
      n_acc     <= '0;
      sym_out   <= '0;
      sym_len   <= '0;
      sym_valid <= 1'b0;
      code_err  <= 1'b0;
    end else begin
      code_err <= 1'b0;
      case (state)
        IDLE: begin
          if (tbl_build) begin
            state    <= BUILD;
            bld_sel  <= tbl_sel;
            bld_idx  <= '0;
            code_acc <= '0;
            k_acc    <= '0;
          end else if (dec_start) begin
            state <= DECODE;
            dsel  <= dec_tbl;
            c_acc <= '0;
            n_acc <= '0;
          end
        end
        BUILD: begin
          code_acc <= (code_acc + CODE_W'(bld_bits)) << 1;
          k_acc    <= k_acc + 9'(bld_bits);
          bld_idx  <= bld_idx + 1'b1;
          if (bld_idx == LIDX_W'(MAX_CODE_LEN - 1)) state <= IDLE;
        end
        DECODE: begin
          if (bit_valid) begin
            c_acc <= c_nxt;
            n_acc <= n_nxt;
            if (match) begin
              sym_out   <= val_data;
              sym_len   <= n_nxt;
              sym_valid <= 1'b1;
              state     <= OUTPUT;
            end else if (n_nxt == LEN_W'(MAX_CODE_LEN)) begin
              code_err <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        OUTPUT: begin
          if (sym_ready) begin
            sym_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tbl_busy  = (state == BUILD);
  assign dec_busy  = (state != IDLE);
  assign bit_ready = (state == DECODE);
endmodule
